// File: rtl/au_seq.sv
// rtl/au_seq.sv - sequential arithmetic unit: ADD, MOV, fractional MUL and DIV with RQ/RD temps
//
// Q(W-FRAC).FRAC signed fixed-point unit fed by router_b. One operation runs per accepted start.
// The result lands in Y and, if selected, in the RQ/RD temp registers at the same edge.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   R, S, I             operands (I is the ADD immediate: 0, +1 or -1)
//   msb_R, msb_S        operand signs
//   op                  00 ADD, 01 MUL, 10 DIV, 11 MOV
//   wb_sel              bit0 writes RQ, bit1 writes RD
//   start               request, taken only when busy is low
//   busy                an iterative MUL/DIV is in progress
//   done                one-cycle pulse: Y/RQ/RD/ovf just updated
//   ovf                 saturation or divide-by-zero on the last result
//   Y, RQ, RD           result and temp registers
module au_seq #(
  parameter int W    = 24,
  parameter int FRAC = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] R,
  input  logic [W-1:0] S,
  input  logic [W-1:0] I,
  input  logic         msb_R,
  input  logic         msb_S,
  input  logic [1:0]   op,
  input  logic [1:0]   wb_sel,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         ovf,
  output logic [W-1:0] Y,
  output logic [W-1:0] RQ,
  output logic [W-1:0] RD
);

  localparam int DW = W + FRAC;          // dividend width and DIV iteration count
  localparam int PW = 2 * W;             // full product width
  localparam int CW = $clog2(DW + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  localparam logic [W-1:0]  Y_MAX    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  Y_MIN    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]  ONE      = W'(1);
  localparam logic [PW-1:0] MAG_MAX  = {{(PW-W){1'b0}}, Y_MAX};
  localparam logic [PW-1:0] MAG_MIN  = {{(PW-W){1'b0}}, Y_MIN};
  localparam logic [CW-1:0] MUL_LAST = CW'(W - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t        state;
  logic [1:0]    op_q;
  logic [1:0]    wb_q;
  logic          neg_q;       // result sign for MUL/DIV
  logic          sgn_r_q;     // sign of R, picks the divide-by-zero limit
  logic          szero_q;     // divisor was zero
  logic [CW-1:0] cnt;

  // Shift-add multiplier: multiplicand moves left, multiplier bits consumed LSB first.
  logic [PW-1:0] mcand;
  logic [W-1:0]  mplier;
  logic [PW-1:0] prod;

  // Restoring divider: dq shifts dividend bits out the top and quotient bits in the bottom.
  logic [W-1:0]  rem;
  logic [DW-1:0] dq;
  logic [W-1:0]  divisor;

  // Magnitudes are unsigned W-bit values, so the most negative input maps to 2^(W-1) cleanly.
  logic [W-1:0]    abs_r, abs_s;
  logic [PW-1:0]   prod_nx;
  logic [W:0]      rem_t;
  logic            rem_ge;
  logic [W-1:0]    rem_nx;
  logic [DW-1:0]   dq_nx;
  logic [PW-1:0]   mag;
  logic signed [W+1:0] sum;
  logic [W-1:0]    acc_y, fin_y;
  logic            acc_ovf, fin_ovf;
  logic            iter_last;

  always_comb begin
    abs_r = msb_R ? (~R + ONE) : R;
    abs_s = msb_S ? (~S + ONE) : S;

    prod_nx = mplier[0] ? (prod + mcand) : prod;

    rem_t  = {rem, dq[DW-1]};
    rem_ge = (rem_t >= {1'b0, divisor});
    // The remainder after a successful subtract is below the divisor, so W bits suffice.
    rem_nx = rem_ge ? (rem_t[W-1:0] - divisor) : rem_t[W-1:0];
    dq_nx  = {dq[DW-2:0], rem_ge};

    iter_last = (op_q == OP_MUL) ? (cnt == MUL_LAST) : (cnt == DIV_LAST);

    // Result of an operation completing directly from the input operands.
    sum     = $signed({{2{R[W-1]}}, R}) + $signed({{2{S[W-1]}}, S}) + $signed({{2{I[W-1]}}, I});
    acc_y   = R;
    acc_ovf = 1'b0;
    if (op == OP_ADD) begin
      if (sum > $signed({2'b00, Y_MAX})) begin
        acc_y   = Y_MAX;
        acc_ovf = 1'b1;
      end else if (sum < $signed({2'b11, Y_MIN})) begin
        acc_y   = Y_MIN;
        acc_ovf = 1'b1;
      end else begin
        acc_y = sum[W-1:0];
      end
    end

    // Result of the iterative operation, taken from the final iteration's next values.
    if (op_q == OP_MUL) begin
      mag = {{FRAC{1'b0}}, prod_nx[PW-1:FRAC]};
    end else begin
      mag = {{(PW-DW){1'b0}}, dq_nx};
    end
    fin_ovf = 1'b0;
    if (op_q == OP_DIV && szero_q) begin
      fin_y   = sgn_r_q ? Y_MIN : Y_MAX;
      fin_ovf = 1'b1;
    end else if (neg_q) begin
      if (mag > MAG_MIN) begin
        fin_y   = Y_MIN;
        fin_ovf = 1'b1;
      end else begin
        fin_y = ~mag[W-1:0] + ONE;
      end
    end else begin
      if (mag > MAG_MAX) begin
        fin_y   = Y_MAX;
        fin_ovf = 1'b1;
      end else begin
        fin_y = mag[W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      Y       <= '0;
      RQ      <= '0;
      RD      <= '0;
      op_q    <= OP_ADD;
      wb_q    <= 2'b00;
      neg_q   <= 1'b0;
      sgn_r_q <= 1'b0;
      szero_q <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      rem     <= '0;
      dq      <= '0;
      divisor <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // FIX is the done cycle; it accepts a new start exactly like IDLE.
        IDLE, FIX: begin
          state <= IDLE;
          if (start) begin
            if (op == OP_ADD || op == OP_MOV) begin
              Y     <= acc_y;
              ovf   <= acc_ovf;
              done  <= 1'b1;
              state <= FIX;
              if (wb_sel[0]) RQ <= acc_y;
              if (wb_sel[1]) RD <= acc_y;
            end else begin
              busy    <= 1'b1;
              state   <= ITER;
              op_q    <= op;
              wb_q    <= wb_sel;
              neg_q   <= msb_R ^ msb_S;
              sgn_r_q <= msb_R;
              szero_q <= (S == '0);
              cnt     <= '0;
              mcand   <= {{(PW-W){1'b0}}, abs_r};
              mplier  <= abs_s;
              prod    <= '0;
              rem     <= '0;
              dq      <= {abs_r, {FRAC{1'b0}}};
              divisor <= abs_s;
            end
          end
        end
        ITER: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          prod   <= prod_nx;
          rem    <= rem_nx;
          dq     <= dq_nx;
          cnt    <= cnt + CW'(1);
          if (iter_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIX;
            Y     <= fin_y;
            ovf   <= fin_ovf;
            if (wb_q[0]) RQ <= fin_y;
            if (wb_q[1]) RD <= fin_y;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_au_seq.sv
// tb/tb_au_seq.sv - randomized self-checking bench for au_seq against an arithmetic reference model
module tb_au_seq;

  localparam int W    = 24;
  localparam int FRAC = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] R, S, I;
  logic         msb_R, msb_S;
  logic [1:0]   op, wb_sel;
  logic         start;
  logic         busy, done, ovf;
  logic [W-1:0] Y, RQ, RD;

  assign msb_R = R[W-1];
  assign msb_S = S[W-1];

  always #5 clk = ~clk;

  au_seq #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .R(R), .S(S), .I(I), .msb_R(msb_R), .msb_S(msb_S),
    .op(op), .wb_sel(wb_sel), .start(start), .busy(busy), .done(done), .ovf(ovf),
    .Y(Y), .RQ(RQ), .RD(RD)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] m_rq = '0;
  logic [W-1:0] m_rd = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic longint sx(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint mag_of(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: exact integer arithmetic, then clamp to the signed W-bit range.
  function automatic void ref_model(input logic [1:0] o, input logic [W-1:0] r, input logic [W-1:0] s,
                                    input logic [W-1:0] i, output logic [W-1:0] y, output logic of);
    longint mx, mn, v, a, b;
    logic   neg;
    mx  = (longint'(1) << (W-1)) - 1;
    mn  = -(longint'(1) << (W-1));
    a   = mag_of(sx(r));
    b   = mag_of(sx(s));
    neg = (sx(r) < 0) != (sx(s) < 0);
    v   = 0;
    case (o)
      OP_ADD: v = sx(r) + sx(s) + sx(i);
      OP_MOV: v = sx(r);
      OP_MUL: begin
        v = (a * b) >> FRAC;
        if (neg) v = -v;
      end
      default: begin
        if (b == 0) begin
          y  = (sx(r) < 0) ? W'(mn) : W'(mx);
          of = 1'b1;
          return;
        end
        v = (a << FRAC) / b;
        if (neg) v = -v;
      end
    endcase
    if (v > mx) begin
      y = W'(mx); of = 1'b1;
    end else if (v < mn) begin
      y = W'(mn); of = 1'b1;
    end else begin
      y = W'(v); of = 1'b0;
    end
  endfunction

  // Issues one op, optionally pokes start while busy, scrambles inputs after accept,
  // and checks latency, busy, result and temp registers against the model.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] r, input logic [W-1:0] s,
                       input logic [W-1:0] i, input logic [1:0] wb, input bit poke);
    logic [W-1:0] ey;
    logic         eo;
    int           lat, exp_lat;
    ref_model(o, r, s, i, ey, eo);
    exp_lat = (o == OP_MUL) ? W + 1 : (o == OP_DIV) ? W + FRAC + 1 : 1;
    op = o; R = r; S = s; I = i; wb_sel = wb; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    R      = W'($urandom());
    S      = W'($urandom());
    I      = W'($urandom());
    op     = 2'($urandom());
    wb_sel = 2'($urandom());
    lat    = 1;
    while (!done && lat < 100) begin
      check_val("busy_during_op", 64'(busy), 64'(1));
      if (poke) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (wb[0]) m_rq = ey;
    if (wb[1]) m_rd = ey;
    check_val("latency", 64'(lat), 64'(exp_lat));
    check_val("busy_at_done", 64'(busy), 64'(0));
    check_val("Y", 64'(Y), 64'(ey));
    check_val("ovf", 64'(ovf), 64'(eo));
    check_val("RQ", 64'(RQ), 64'(m_rq));
    check_val("RD", 64'(RD), 64'(m_rd));
  endtask

  function automatic logic [W-1:0] rnd_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = W'($urandom());
      1: v = W'($urandom_range(0, 'h7FFFF));
      2: v = -W'($urandom_range(0, 'h7FFFF));
      3: v = W'($urandom_range(0, 'h3FFFF)) << 4;
      default: begin
        case ($urandom_range(0, 4))
          0: v = 24'h800000;
          1: v = 24'h7FFFFF;
          2: v = 24'h000000;
          3: v = 24'hFFFFFF;
          default: v = 24'h000001;
        endcase
      end
    endcase
    return v;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int           seen;
    logic [1:0]   ro;
    logic [W-1:0] ri;

    rst = 1'b1; start = 1'b0; R = '0; S = '0; I = '0; op = OP_ADD; wb_sel = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 64'(busy), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_ovf", 64'(ovf), 64'(0));
    check_val("rst_Y", 64'(Y), 64'(0));
    check_val("rst_RQ", 64'(RQ), 64'(0));
    check_val("rst_RD", 64'(RD), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(OP_ADD, 24'h000005, 24'hFFFFFC, 24'h000001, 2'b01, 1'b0);
    do_op(OP_MUL, 24'h018000, 24'hFE0000, 24'h000000, 2'b10, 1'b1);
    do_op(OP_DIV, 24'h010000, 24'h040000, 24'h000000, 2'b00, 1'b1);
    do_op(OP_DIV, 24'hFF0000, 24'h000000, 24'h000000, 2'b01, 1'b0);
    do_op(OP_DIV, 24'h000000, 24'h000000, 24'h000000, 2'b00, 1'b0);
    do_op(OP_MUL, 24'h7F0000, 24'h020000, 24'h000000, 2'b00, 1'b0);
    do_op(OP_ADD, 24'h7FFFFF, 24'h000001, 24'h000000, 2'b10, 1'b0);
    do_op(OP_ADD, 24'h800000, 24'hFFFFFF, 24'hFFFFFF, 2'b11, 1'b0);
    do_op(OP_MOV, 24'h800000, 24'h123456, 24'h000001, 2'b11, 1'b0);
    do_op(OP_MUL, 24'h800000, 24'h800000, 24'h000000, 2'b01, 1'b0);
    do_op(OP_MUL, 24'h800000, 24'h010000, 24'h000000, 2'b10, 1'b0);
    do_op(OP_DIV, 24'h800000, 24'h010000, 24'h000000, 2'b01, 1'b0);
    do_op(OP_DIV, 24'hFFFFFF, 24'h030000, 24'h000000, 2'b10, 1'b0);

    // Reset in the middle of a MUL: no writeback and no late done.
    op = OP_MUL; R = 24'h018000; S = 24'hFE0000; I = '0; wb_sel = 2'b11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    m_rq = '0;
    m_rd = '0;
    check_val("midrst_busy", 64'(busy), 64'(0));
    check_val("midrst_done", 64'(done), 64'(0));
    check_val("midrst_Y", 64'(Y), 64'(0));
    check_val("midrst_RQ", 64'(RQ), 64'(0));
    check_val("midrst_RD", 64'(RD), 64'(0));
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check_val("no_done_after_rst", 64'(seen), 64'(0));

    do_op(OP_MUL, 24'h018000, 24'hFE0000, 24'h000000, 2'b11, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom());
      case ($urandom_range(0, 2))
        0: ri = 24'h000000;
        1: ri = 24'h000001;
        default: ri = 24'hFFFFFF;
      endcase
      do_op(ro, rnd_operand(), rnd_operand(), ri, 2'($urandom()), 1'($urandom_range(0, 1)));
    end

    @(posedge clk); #1;
    check_val("done_single_pulse", 64'(done), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
